seg7_scanner: RTL and testbench

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/seg7_scanner.sv | 99 +++++++++
 tb/tb_seg7_scanner.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: digit count, glyph table, blank pattern.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [1:0] i);
        anode_sel    = '1;
        anode_sel[i] = 1'b0;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment glyph, purely combinational.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPHS[value];

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot and anti-ghost blanking.
// Optional leading-zero blanking when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      snap;
    logic [3:0]       snap_dp;

    logic             cnt_wrap;
    logic [3:0]       cur_digit;
    logic [6:0]       glyph;
    logic [3:0]       keep;
    logic             lit;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    assign cnt_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            idx     <= '0;
            snap    <= '0;
            snap_dp <= '0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= idx + 2'd1;
                // Frame boundary: take a coherent copy so no frame mixes old and new digits
                if (idx == 2'd3) begin
                    snap    <= digits;
                    snap_dp <= dp_in;
                end
            end
        end
    end

    assign cur_digit = snap[{idx, 2'b00} +: 4];

    seg7_decoder u_decoder (
        .value (cur_digit),
        .seg   (glyph)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit stays dark only if it and everything above it is zero and it has no dp lit
    always_comb begin
        keep    = 4'b0001;
        keep[1] = (snap[15:4]  != 12'h000) | snap_dp[1];
        keep[2] = (snap[15:8]  != 8'h00)   | snap_dp[2];
        keep[3] = (snap[15:12] != 4'h0)    | snap_dp[3];
    end
`else
    assign keep = 4'b1111;
`endif

    always_comb begin
        lit   = enable && (32'(cnt) >= 32'(BLANK_CYCLES)) && keep[idx];
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = anode_sel(idx);
            seg_d = glyph;
            dp_d  = ~snap_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner (REFRESH_DIV=4, BLANK_CYCLES=1); honours SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int compared   = 0;
    int mismatched = 0;

    seg7_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .digits (digits),
        .dp_in  (dp_in),
        .enable (enable),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp_in;
        logic [3:0][6:0] seg;     // expected glyph, indexed by idx
        logic [3:0]      dpo;     // expected dp cathode per idx
        logic [3:0]      lit;     // which idx slots light up
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         k;
    } exp_t;

    vec_t tbl [7];
    exp_t sb [$];
    logic [3:0] frame0_lit;

    task automatic check(input string name, input int k, input logic [11:0] got, input logic [11:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s step=%0d got=%h want=%h", name, k, got, want);
        end
    endtask

    // One clock: drive enable, predict the registered output of this edge, then compare at negedge
    task automatic step(input int k, input logic en_i);
        exp_t e;
        int   j, f, c, id;
        logic [3:0] mask;
        logic [6:0] sv;
        logic       dv;
        logic       lit;
        logic [3:0] onehot;
        enable = en_i;
        j  = k - 1;
        f  = j / 16;
        c  = j % 4;
        id = (j / 4) % 4;
        if (f == 0) begin
            mask = frame0_lit;
            sv   = 7'h40;
            dv   = 1'b1;
        end else begin
            mask = tbl[f-1].lit;
            sv   = tbl[f-1].seg[id];
            dv   = tbl[f-1].dpo[id];
        end
        lit = en_i && (c >= 1) && mask[id];
        onehot = 4'b0001 << id;
        e.k   = k;
        e.an  = lit ? ~onehot : 4'b1111;
        e.seg = lit ? sv : 7'h7F;
        e.dp  = lit ? dv : 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("an",  e.k, {8'h0, an},  {8'h0, e.an});
        check("seg", e.k, {5'h0, seg}, {5'h0, e.seg});
        check("dp",  e.k, {11'h0, dp}, {11'h0, e.dp});
    endtask

    task automatic check_reset_vals(input string name, input int k);
        check({name, "_an"},  k, {8'h0, an},  12'h00F);
        check({name, "_seg"}, k, {5'h0, seg}, 12'h07F);
        check({name, "_dp"},  k, {11'h0, dp}, 12'h001);
    endtask

    initial begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        frame0_lit = 4'b0001;
        tbl[4] = '{16'h0E00, 4'b0000, {7'h40, 7'h06, 7'h40, 7'h40}, 4'b1111, 4'b0111};
        tbl[5] = '{16'h0007, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111, 4'b0001};
        tbl[6] = '{16'h0007, 4'b0100, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1011, 4'b0101};
`else
        frame0_lit = 4'b1111;
        tbl[4] = '{16'h0E00, 4'b0000, {7'h40, 7'h06, 7'h40, 7'h40}, 4'b1111, 4'b1111};
        tbl[5] = '{16'h0007, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111, 4'b1111};
        tbl[6] = '{16'h0007, 4'b0100, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1011, 4'b1111};
`endif
        tbl[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111};
        tbl[1] = '{16'h5678, 4'b0000, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, 4'b1111};
        tbl[2] = '{16'hF00A, 4'b0001, {7'h0E, 7'h40, 7'h40, 7'h08}, 4'b1110, 4'b1111};
        tbl[3] = '{16'h9BCD, 4'b1010, {7'h10, 7'h03, 7'h46, 7'h21}, 4'b0101, 4'b1111};

        rst    = 1'b0;
        digits = 16'h1234;
        dp_in  = 4'b0000;
        enable = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals("reset_hold", i);
        end
        rst = 1'b1;

        // Next vector is applied mid-frame; the snapshot must keep the current frame intact
        for (int k = 1; k <= 115; k++) begin
            if ((k % 16) == 5 && (k / 16) < 7) begin
                digits = tbl[k/16].digits;
                dp_in  = tbl[k/16].dp_in;
            end
            step(k, !(k >= 70 && k <= 75));
        end

        // Asynchronous reset while idx0 is lit, mid-slot, with clk low
        #2 rst = 1'b0;
        #1 check_reset_vals("reset_async", 0);
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_async_hold", 1);
        rst = 1'b1;

        for (int k = 1; k <= 6; k++) begin
            step(k, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
